rftpu_batch_sequencer: RTL and testbench

Command-driven sequencer that runs a batch of N tile operations on the `rftpu_systolic_v21` array. For each operation it:
- issues the `start` pulse,
- streams ARRAY_DIM weight rows from a valid/ready source into the array's direct weight-load port,
- presents one activation vector,
- waits for `done`.

It sits between the host command path and the array. It replaces the hand-sequenced start/load/wait flow with a synthesizable controller, and reports operation count and cycle count for performance accounting.

---
 rtl/rftpu_batch_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_rftpu_batch_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rftpu_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rftpu_batch_sequencer
// Purpose  : Runs a batch of N tile operations on the rftpu_systolic_v21
//            array. For each operation it pulses start, streams ARRAY_DIM
//            weight rows from a valid/ready source, presents one activation
//            vector and waits for done. It reports the number of operations
//            finished and the number of cycles from accept to completion.
// Ports    : cmd_*      - batch command handshake (num_ops, mode)
//            abort      - synchronous abort of the running batch
//            wsrc_*     - weight-row valid/ready source
//            act_*      - activation-vector valid/ready source
//            arr_*      - array control, weight-load port and status
//            seq_*, ops_completed, cycle_count, err_timeout - status
// Options  : `define RFTPU_SEQ_WATCHDOG_EN adds a per-state stall watchdog,
//            the ERR state and the sticky err_timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module rftpu_batch_sequencer #(
    parameter int unsigned ARRAY_DIM       = 16,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned WATCHDOG_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [15:0]                     cmd_num_ops,
    input  logic [3:0]                      cmd_mode,
    input  logic                            abort,
    input  logic                            wsrc_valid,
    output logic                            wsrc_ready,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] wsrc_data,
    input  logic                            act_valid,
    output logic                            act_ready,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] act_data,
    output logic                            arr_start,
    output logic [3:0]                      arr_mode,
    output logic                            arr_weight_load_en,
    output logic [$clog2(ARRAY_DIM)-1:0]    arr_weight_row_sel,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] arr_weight_data,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] arr_activation_data,
    input  logic                            arr_ready_for_weights,
    input  logic                            arr_ready_for_activation,
    input  logic                            arr_done,
    output logic                            seq_busy,
    output logic                            seq_done,
    output logic [15:0]                     ops_completed,
    output logic [31:0]                     cycle_count,
    output logic                            err_timeout
);

    localparam int unsigned c_row_w = $clog2(ARRAY_DIM);
    localparam int unsigned c_vec_w = ARRAY_DIM * DATA_WIDTH;
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ARRAY_DIM - 1);

`ifdef RFTPU_SEQ_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_WAIT_W = 3'd2, S_LOAD_W = 3'd3,
        S_WAIT_A = 3'd4, S_WAIT_DONE = 3'd5, S_NEXT = 3'd6, S_ERR = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_WAIT_W = 3'd2, S_LOAD_W = 3'd3,
        S_WAIT_A = 3'd4, S_WAIT_DONE = 3'd5, S_NEXT = 3'd6
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [15:0]          num_ops_q, num_ops_d;
    logic [3:0]           mode_q, mode_d;
    logic [c_row_w-1:0]   row_cnt_q, row_cnt_d;
    logic [c_row_w-1:0]   wrow_q, wrow_d;
    logic                 load_en_q, load_en_d;
    logic [c_vec_w-1:0]   wdata_q, wdata_d;
    logic [c_vec_w-1:0]   adata_q, adata_d;
    logic                 seq_done_q, seq_done_d;
    logic [15:0]          ops_q, ops_d;
    logic [31:0]          cyc_q, cyc_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic                 wsrc_ready_q, wsrc_ready_d;
`ifdef RFTPU_SEQ_WATCHDOG_EN
    logic                 err_q, err_d;
    logic [31:0]          wd_cnt_q, wd_cnt_d;
`endif

    logic w_wsrc_hs;
    logic w_act_hs;

    // act_ready follows the array's readiness directly so no cycle is lost.
    assign act_ready = (state_q == S_WAIT_A) && arr_ready_for_activation;
    assign w_wsrc_hs = wsrc_valid && wsrc_ready_q;
    assign w_act_hs  = act_valid && act_ready;

    always_comb begin
        state_d      = state_q;
        num_ops_d    = num_ops_q;
        mode_d       = mode_q;
        row_cnt_d    = row_cnt_q;
        wrow_d       = wrow_q;
        load_en_d    = 1'b0;
        wdata_d      = wdata_q;
        adata_d      = adata_q;
        seq_done_d   = 1'b0;
        ops_d        = ops_q;
        cyc_d        = cyc_q;
`ifdef RFTPU_SEQ_WATCHDOG_EN
        err_d        = err_q;
`endif
        // Counts every busy cycle, saturating rather than wrapping.
        if ((state_q != S_IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    num_ops_d = cmd_num_ops;
                    mode_d    = cmd_mode;
                    ops_d     = 16'd0;
                    cyc_d     = 32'd1;      // the accept cycle itself counts
`ifdef RFTPU_SEQ_WATCHDOG_EN
                    err_d     = 1'b0;
`endif
                    if (cmd_num_ops == 16'd0) begin
                        seq_done_d = 1'b1;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START:  state_d = S_WAIT_W;
            S_WAIT_W: begin
                if (arr_ready_for_weights) state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (w_wsrc_hs) begin
                    wdata_d   = wsrc_data;
                    load_en_d = 1'b1;
                    wrow_d    = row_cnt_q;
                    if (row_cnt_q == c_row_last) begin
                        row_cnt_d = '0;
                        state_d   = S_WAIT_A;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_A: begin
                if (w_act_hs) begin
                    adata_d = act_data;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (arr_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                ops_d = ops_q + 16'd1;
                if ((ops_q + 16'd1) == num_ops_q) begin
                    seq_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_START;
                end
            end
`ifdef RFTPU_SEQ_WATCHDOG_EN
            S_ERR:    state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase

`ifdef RFTPU_SEQ_WATCHDOG_EN
        // Stall only when the state did not advance on the limit cycle.
        if (((state_q == S_WAIT_W) || (state_q == S_LOAD_W) ||
             (state_q == S_WAIT_A) || (state_q == S_WAIT_DONE)) &&
            (state_d == state_q) && (wd_cnt_q == 32'(WATCHDOG_CYCLES - 1))) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end
        wd_cnt_d = (state_d == state_q) ? (wd_cnt_q + 32'd1) : 32'd0;
`endif

        // Abort outranks every event evaluated above.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            load_en_d  = 1'b0;
            seq_done_d = 1'b0;
            row_cnt_d  = '0;
            wrow_d     = wrow_q;
            wdata_d    = wdata_q;
            adata_d    = adata_q;
            ops_d      = ops_q;
            cyc_d      = cyc_q;
`ifdef RFTPU_SEQ_WATCHDOG_EN
            err_d      = err_q;
            wd_cnt_d   = 32'd0;
`endif
        end

        cmd_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        start_d      = (state_d == S_START);
        wsrc_ready_d = (state_d == S_LOAD_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            num_ops_q    <= '0;
            mode_q       <= '0;
            row_cnt_q    <= '0;
            wrow_q       <= '0;
            load_en_q    <= 1'b0;
            wdata_q      <= '0;
            adata_q      <= '0;
            seq_done_q   <= 1'b0;
            ops_q        <= '0;
            cyc_q        <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            wsrc_ready_q <= 1'b0;
`ifdef RFTPU_SEQ_WATCHDOG_EN
            err_q        <= 1'b0;
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            num_ops_q    <= num_ops_d;
            mode_q       <= mode_d;
            row_cnt_q    <= row_cnt_d;
            wrow_q       <= wrow_d;
            load_en_q    <= load_en_d;
            wdata_q      <= wdata_d;
            adata_q      <= adata_d;
            seq_done_q   <= seq_done_d;
            ops_q        <= ops_d;
            cyc_q        <= cyc_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            wsrc_ready_q <= wsrc_ready_d;
`ifdef RFTPU_SEQ_WATCHDOG_EN
            err_q        <= err_d;
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign seq_busy            = busy_q;
    assign arr_start           = start_q;
    assign wsrc_ready          = wsrc_ready_q;
    assign arr_mode            = mode_q;
    assign arr_weight_load_en  = load_en_q;
    assign arr_weight_row_sel  = wrow_q;
    assign arr_weight_data     = wdata_q;
    assign arr_activation_data = adata_q;
    assign seq_done            = seq_done_q;
    assign ops_completed       = ops_q;
    assign cycle_count         = cyc_q;
`ifdef RFTPU_SEQ_WATCHDOG_EN
    assign err_timeout         = err_q;
`else
    assign err_timeout         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rftpu_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rftpu_batch_sequencer
// Purpose  : Self-checking bench for rftpu_batch_sequencer. Drives randomized
//            weight/activation sources and a simple array model, logs the
//            observed strobes and handshakes, and compares them against
//            expectations derived from batch-level rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rftpu_batch_sequencer;

    localparam int DIM = 16;
    localparam int DW  = 8;
    localparam int VW  = DIM * DW;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [15:0]     cmd_num_ops;
    logic [3:0]      cmd_mode;
    logic            abort;
    logic            wsrc_valid;
    logic            wsrc_ready;
    logic [VW-1:0]   wsrc_data;
    logic            act_valid;
    logic            act_ready;
    logic [VW-1:0]   act_data;
    logic            arr_start;
    logic [3:0]      arr_mode;
    logic            arr_weight_load_en;
    logic [3:0]      arr_weight_row_sel;
    logic [VW-1:0]   arr_weight_data;
    logic [VW-1:0]   arr_activation_data;
    logic            arr_ready_for_weights;
    logic            arr_ready_for_activation;
    logic            arr_done;
    logic            seq_busy;
    logic            seq_done;
    logic [15:0]     ops_completed;
    logic [31:0]     cycle_count;
    logic            err_timeout;

    rftpu_batch_sequencer #(
        .ARRAY_DIM       (DIM),
        .DATA_WIDTH      (DW),
        .WATCHDOG_CYCLES (64)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_num_ops              (cmd_num_ops),
        .cmd_mode                 (cmd_mode),
        .abort                    (abort),
        .wsrc_valid               (wsrc_valid),
        .wsrc_ready               (wsrc_ready),
        .wsrc_data                (wsrc_data),
        .act_valid                (act_valid),
        .act_ready                (act_ready),
        .act_data                 (act_data),
        .arr_start                (arr_start),
        .arr_mode                 (arr_mode),
        .arr_weight_load_en       (arr_weight_load_en),
        .arr_weight_row_sel       (arr_weight_row_sel),
        .arr_weight_data          (arr_weight_data),
        .arr_activation_data      (arr_activation_data),
        .arr_ready_for_weights    (arr_ready_for_weights),
        .arr_ready_for_activation (arr_ready_for_activation),
        .arr_done                 (arr_done),
        .seq_busy                 (seq_busy),
        .seq_done                 (seq_done),
        .ops_completed            (ops_completed),
        .cycle_count              (cycle_count),
        .err_timeout              (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Observation logs and model state
    int  n_start, n_done, st_first, acc_t, done_stamp, a_t;
    int  done_cnt   = 0;
    int  done_delay = 20;
    int  w_mode     = 0;
    bit  cmd_pend   = 1'b0;
    bit  abort_pend = 1'b0;
    bit  never_done = 1'b0;
    bit  rdy_rand   = 1'b0;
    bit  act_cap    = 1'b0;
    int            s_row[$];
    int            s_t[$];
    int            h_t[$];
    logic [VW-1:0] s_data[$];
    logic [VW-1:0] h_data[$];
    logic [VW-1:0] a_exp[$];
    logic [VW-1:0] a_obs[$];

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_logs();
        n_start = 0; n_done = 0; st_first = -1; acc_t = -1; done_stamp = -1; a_t = -1;
        s_row.delete(); s_t.delete(); s_data.delete();
        h_t.delete(); h_data.delete(); a_exp.delete(); a_obs.delete();
        act_cap = 1'b0;
    endtask

    // One clock: sample outputs at negedge, drive new inputs, then log the
    // handshakes that will fire on the coming posedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (arr_start) begin
            n_start++;
            if (st_first < 0) st_first = cyc;
        end
        if (seq_done) begin n_done++; done_stamp = cyc; end
        if (arr_weight_load_en) begin
            s_row.push_back(int'(arr_weight_row_sel));
            s_data.push_back(arr_weight_data);
            s_t.push_back(cyc);
        end
        if (act_cap) begin a_obs.push_back(arr_activation_data); act_cap = 1'b0; end
        cmd_valid  = cmd_pend;
        abort      = abort_pend;
        abort_pend = 1'b0;
        case (w_mode)
            0:       wsrc_valid = 1'b1;
            1:       wsrc_valid = ~wsrc_valid;
            default: wsrc_valid = ($urandom_range(0, 99) < 60);
        endcase
        wsrc_data = rand_vec();
        act_valid = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        act_data  = rand_vec();
        arr_ready_for_weights    = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        arr_ready_for_activation = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        arr_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0 && !never_done) arr_done = 1'b1;
        end
        #1;
        if (cmd_valid && cmd_ready) begin cmd_pend = 1'b0; acc_t = cyc; end
        if (!abort && wsrc_valid && wsrc_ready) begin
            h_data.push_back(wsrc_data);
            h_t.push_back(cyc);
        end
        if (!abort && act_valid && act_ready) begin
            a_exp.push_back(act_data);
            act_cap  = 1'b1;
            a_t      = cyc;
            done_cnt = done_delay;
        end
    endtask

    task automatic run_batch(input int n, input logic [3:0] mode, input int budget, output bit ok);
        clear_logs();
        cmd_num_ops = 16'(n);
        cmd_mode    = mode;
        cmd_pend    = 1'b1;
        ok          = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_done != 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_num_ops = '0; cmd_mode = '0; abort = 1'b0;
        wsrc_valid = 1'b0; wsrc_data = '0; act_valid = 1'b0; act_data = '0;
        arr_ready_for_weights = 1'b0; arr_ready_for_activation = 1'b0; arr_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if ({cmd_ready, seq_busy, seq_done, arr_start, arr_weight_load_en, wsrc_ready, act_ready, err_timeout} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 10000000",
                     {cmd_ready, seq_busy, seq_done, arr_start, arr_weight_load_en, wsrc_ready, act_ready, err_timeout});
        end
        total++;
        if ({arr_mode, arr_weight_row_sel, ops_completed, cycle_count} !== 56'd0 ||
            arr_weight_data !== '0 || arr_activation_data !== '0) begin
            bad++;
            $display("FAIL reset_data: mode=%0d row=%0d ops=%0d cyc=%0d required all 0",
                     arr_mode, arr_weight_row_sel, ops_completed, cycle_count);
        end
    endtask

    task automatic test_basic();
        bit ok;
        w_mode = 0; rdy_rand = 1'b0; done_delay = 20; never_done = 1'b0;
        run_batch(3, 4'hF, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done: seq_done not seen, required within 1000 cycles"); end
        total++; if (ops_completed !== 16'd3) begin bad++; $display("FAIL basic_ops: got %0d required 3", ops_completed); end
        total++; if (cycle_count !== 32'd121) begin bad++; $display("FAIL basic_cycles: got %0d required 121", cycle_count); end
        total++; if (arr_mode !== 4'hF) begin bad++; $display("FAIL basic_mode: got %h required f", arr_mode); end
        total++; if (st_first !== acc_t + 1) begin bad++; $display("FAIL basic_start_lat: got t=%0d required t=%0d", st_first, acc_t + 1); end
        total++; if (!cmd_ready || seq_busy) begin bad++; $display("FAIL basic_idle: ready=%b busy=%b required 1/0", cmd_ready, seq_busy); end
        step(); step();
        total++; if (n_start != 3) begin bad++; $display("FAIL basic_starts: got %0d required 3", n_start); end
        total++; if (n_done != 1) begin bad++; $display("FAIL basic_seq_done: got %0d pulses required 1", n_done); end
        total++; if (s_row.size() != 48 || h_t.size() != 48) begin bad++; $display("FAIL basic_strobes: got %0d strobes %0d handshakes required 48", s_row.size(), h_t.size()); end
        for (int i = 0; i < s_row.size() && i < h_t.size(); i++) begin
            total++;
            if (s_row[i] != i % DIM || s_t[i] != h_t[i] + 1 || s_data[i] !== h_data[i]) begin
                bad++;
                $display("FAIL basic_strobe[%0d]: row=%0d t=%0d data=%h required row=%0d t=%0d data=%h",
                         i, s_row[i], s_t[i], s_data[i], i % DIM, h_t[i] + 1, h_data[i]);
            end
        end
        total++;
        if (a_obs.size() != 3 || a_exp.size() != 3 || a_obs[0] !== a_exp[0] || a_obs[2] !== a_exp[2]) begin
            bad++;
            $display("FAIL basic_act: got %0d vectors required 3 matching handshakes", a_obs.size());
        end
    endtask

    task automatic test_zero_ops();
        bit ok;
        run_batch(0, 4'h5, 20, ok);
        total++; if (!ok || done_stamp != acc_t + 1) begin bad++; $display("FAIL zero_done: got t=%0d required t=%0d", done_stamp, acc_t + 1); end
        total++; if (cycle_count !== 32'd1) begin bad++; $display("FAIL zero_cycles: got %0d required 1", cycle_count); end
        total++; if (ops_completed !== 16'd0 || arr_mode !== 4'h5) begin bad++; $display("FAIL zero_state: ops=%0d mode=%h required 0/5", ops_completed, arr_mode); end
        step(); step();
        total++; if (n_start != 0 || n_done != 1 || seq_busy) begin bad++; $display("FAIL zero_quiet: starts=%0d dones=%0d busy=%b required 0/1/0", n_start, n_done, seq_busy); end
    endtask

    task automatic test_weight_backpressure();
        bit ok;
        w_mode = 1; rdy_rand = 1'b0; done_delay = 4; never_done = 1'b0;
        run_batch(2, 4'h9, 1000, ok);
        total++; if (!ok || ops_completed !== 16'd2) begin bad++; $display("FAIL bp_ops: ok=%b ops=%0d required 1/2", ok, ops_completed); end
        total++; if (cycle_count !== 32'(done_stamp - acc_t)) begin bad++; $display("FAIL bp_cycles: got %0d required %0d", cycle_count, done_stamp - acc_t); end
        total++; if (s_row.size() != 32 || h_t.size() != 32) begin bad++; $display("FAIL bp_strobes: got %0d strobes required 32", s_row.size()); end
        for (int i = 0; i < s_row.size() && i < h_t.size(); i++) begin
            total++;
            if (s_row[i] != i % DIM || s_t[i] != h_t[i] + 1 || s_data[i] !== h_data[i]) begin
                bad++;
                $display("FAIL bp_strobe[%0d]: row=%0d t=%0d required row=%0d t=%0d", i, s_row[i], s_t[i], i % DIM, h_t[i] + 1);
            end
        end
        w_mode = 0;
    endtask

    task automatic test_abort();
        bit ok;
        bit found;
        logic [31:0] c0;
        w_mode = 0; rdy_rand = 1'b0; done_delay = 30; never_done = 1'b0;
        clear_logs();
        cmd_num_ops = 16'd4; cmd_mode = 4'h3; cmd_pend = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step();
            if (a_exp.size() == 2 && done_cnt > 0 && done_cnt < 25) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL abort_reach: op 2 WAIT_DONE not reached"); end
        abort_pend = 1'b1;
        step();
        c0 = cycle_count;
        step();
        done_cnt = 0;
        total++; if (seq_busy || !cmd_ready) begin bad++; $display("FAIL abort_idle: busy=%b ready=%b required 0/1", seq_busy, cmd_ready); end
        total++; if (ops_completed !== 16'd1) begin bad++; $display("FAIL abort_ops: got %0d required 1", ops_completed); end
        total++; if (cycle_count !== c0) begin bad++; $display("FAIL abort_cycles: got %0d required %0d", cycle_count, c0); end
        step();
        total++; if (n_done != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses required 0", n_done); end
        done_delay = 6;
        run_batch(2, 4'h7, 1000, ok);
        step();
        total++;
        if (!ok || ops_completed !== 16'd2 || n_start != 2 || s_row.size() != 32) begin
            bad++;
            $display("FAIL abort_rerun: ok=%b ops=%0d starts=%0d strobes=%0d required 1/2/2/32",
                     ok, ops_completed, n_start, s_row.size());
        end
    endtask

    task automatic test_reset_mid_load();
        w_mode = 0; rdy_rand = 1'b0; done_delay = 5; never_done = 1'b0;
        clear_logs();
        cmd_num_ops = 16'd2; cmd_mode = 4'hA; cmd_pend = 1'b1;
        for (int i = 0; i < 200 && h_t.size() < 8; i++) step();
        total++;
        if (!arr_weight_load_en || arr_weight_row_sel !== 4'd6 || !wsrc_ready) begin
            bad++;
            $display("FAIL rst_mid_pre: load_en=%b row=%0d wsrc_ready=%b required 1/6/1", arr_weight_load_en, arr_weight_row_sel, wsrc_ready);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_ready, seq_busy, seq_done, arr_start, arr_weight_load_en, wsrc_ready, act_ready, err_timeout} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL rst_mid_ctrl: got %b required 10000000",
                     {cmd_ready, seq_busy, seq_done, arr_start, arr_weight_load_en, wsrc_ready, act_ready, err_timeout});
        end
        total++;
        if ({arr_mode, arr_weight_row_sel, ops_completed, cycle_count} !== 56'd0 ||
            arr_weight_data !== '0 || arr_activation_data !== '0) begin
            bad++;
            $display("FAIL rst_mid_data: mode=%0d row=%0d ops=%0d cyc=%0d required all 0",
                     arr_mode, arr_weight_row_sel, ops_completed, cycle_count);
        end
        cmd_pend = 1'b0; done_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_random_batches();
        bit ok;
        int n;
        logic [3:0] mode;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 3);
            mode = 4'($urandom);
            w_mode = 2; rdy_rand = 1'b1; done_delay = $urandom_range(1, 12); never_done = 1'b0;
            run_batch(n, mode, 3000, ok);
            total++;
            if (!ok || ops_completed !== 16'(n) || arr_mode !== mode || n_start != n) begin
                bad++;
                $display("FAIL rand%0d_batch: ok=%b ops=%0d mode=%h starts=%0d required 1/%0d/%h/%0d",
                         it, ok, ops_completed, arr_mode, n_start, n, mode, n);
            end
            total++; if (cycle_count !== 32'(done_stamp - acc_t)) begin bad++; $display("FAIL rand%0d_cycles: got %0d required %0d", it, cycle_count, done_stamp - acc_t); end
            total++; if (s_row.size() != DIM * n || h_t.size() != DIM * n) begin bad++; $display("FAIL rand%0d_strobes: got %0d required %0d", it, s_row.size(), DIM * n); end
            for (int i = 0; i < s_row.size() && i < h_t.size(); i++) begin
                total++;
                if (s_row[i] != i % DIM || s_t[i] != h_t[i] + 1 || s_data[i] !== h_data[i]) begin
                    bad++;
                    $display("FAIL rand%0d_strobe[%0d]: row=%0d t=%0d required row=%0d t=%0d", it, i, s_row[i], s_t[i], i % DIM, h_t[i] + 1);
                end
            end
            for (int i = 0; i < a_obs.size(); i++) begin
                total++;
                if (i >= a_exp.size() || a_obs[i] !== a_exp[i]) begin
                    bad++;
                    $display("FAIL rand%0d_act[%0d]: got %h required handshake data", it, i, a_obs[i]);
                end
            end
        end
        w_mode = 0; rdy_rand = 1'b0;
    endtask

`ifdef RFTPU_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int err_t;
        w_mode = 0; rdy_rand = 1'b0; done_delay = 5; never_done = 1'b1;
        clear_logs();
        cmd_num_ops = 16'd1; cmd_mode = 4'h1; cmd_pend = 1'b1;
        err_t = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (err_timeout && err_t < 0) err_t = cyc;
            if (acc_t >= 0 && cyc > acc_t + 2 && !seq_busy) break;
        end
        total++; if (err_t != a_t + 65) begin bad++; $display("FAIL wd_time: err at t=%0d required t=%0d", err_t, a_t + 65); end
        total++; if (seq_busy || !err_timeout || n_done != 0) begin bad++; $display("FAIL wd_idle: busy=%b err=%b dones=%0d required 0/1/0", seq_busy, err_timeout, n_done); end
        never_done = 1'b0;
        run_batch(1, 4'h2, 1000, ok);
        total++; if (!ok || err_timeout) begin bad++; $display("FAIL wd_clear: ok=%b err=%b required 1/0", ok, err_timeout); end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_ops();
        test_weight_backpressure();
        test_abort();
        test_reset_mid_load();
        test_random_batches();
`ifdef RFTPU_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
